// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one host-memory request/write/read port between two engines.
// Whole bursts are granted and the port stays locked to the owner until its last beat.
module mem_arbiter #(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 64,
  parameter int MEM_DATA_BITS = 64
) (
  input  logic                     clock,
  input  logic                     reset,

  input  logic                     c0_req_valid,
  output logic                     c0_req_ready,
  input  logic                     c0_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]  c0_req_len,
  input  logic [MEM_ADDR_BITS-1:0] c0_req_addr,
  input  logic                     c0_wr_valid,
  input  logic [MEM_DATA_BITS-1:0] c0_wr_bits,
  output logic                     c0_rd_valid,
  output logic [MEM_DATA_BITS-1:0] c0_rd_bits,
  input  logic                     c0_rd_ready,

  input  logic                     c1_req_valid,
  output logic                     c1_req_ready,
  input  logic                     c1_req_opcode,
  input  logic [MEM_LEN_BITS-1:0]  c1_req_len,
  input  logic [MEM_ADDR_BITS-1:0] c1_req_addr,
  input  logic                     c1_wr_valid,
  input  logic [MEM_DATA_BITS-1:0] c1_wr_bits,
  output logic                     c1_rd_valid,
  output logic [MEM_DATA_BITS-1:0] c1_rd_bits,
  input  logic                     c1_rd_ready,

  output logic                     mem_req_valid,
  output logic                     mem_req_opcode,
  output logic [MEM_LEN_BITS-1:0]  mem_req_len,
  output logic [MEM_ADDR_BITS-1:0] mem_req_addr,
  output logic                     mem_wr_valid,
  output logic [MEM_DATA_BITS-1:0] mem_wr_bits,
  input  logic                     mem_rd_valid,
  input  logic [MEM_DATA_BITS-1:0] mem_rd_bits,
  output logic                     mem_rd_ready,

  output logic                     busy,
  output logic                     owner
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [MEM_LEN_BITS-1:0] LP_ONE = {{(MEM_LEN_BITS-1){1'b0}}, 1'b1};

  state_t                  r_state;
  logic                    r_owner;
  logic                    r_rr;
  logic [MEM_LEN_BITS-1:0] r_cnt;

  state_t                  w_state_nxt;
  logic                    w_owner_nxt;
  logic                    w_rr_nxt;
  logic [MEM_LEN_BITS-1:0] w_cnt_nxt;
  logic                    w_sel;
  logic                    w_beat;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_rr    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_rr    <= w_rr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Every output is forced low while reset is held, including the combinational pass-throughs.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_rr_nxt       = r_rr;
    w_cnt_nxt      = r_cnt;
    w_sel          = (c0_req_valid && c1_req_valid) ? r_rr : c1_req_valid;
    w_beat         = 1'b0;
    c0_req_ready   = 1'b0;
    c1_req_ready   = 1'b0;
    c0_rd_valid    = 1'b0;
    c0_rd_bits     = '0;
    c1_rd_valid    = 1'b0;
    c1_rd_bits     = '0;
    mem_req_valid  = 1'b0;
    mem_req_opcode = 1'b0;
    mem_req_len    = '0;
    mem_req_addr   = '0;
    mem_wr_valid   = 1'b0;
    mem_wr_bits    = '0;
    mem_rd_ready   = 1'b0;

    if (reset) begin
      case (r_state)
        ST_IDLE: begin
          if (c0_req_valid || c1_req_valid) begin
            mem_req_valid  = 1'b1;
            mem_req_opcode = w_sel ? c1_req_opcode : c0_req_opcode;
            mem_req_len    = w_sel ? c1_req_len    : c0_req_len;
            mem_req_addr   = w_sel ? c1_req_addr   : c0_req_addr;
            c0_req_ready   = ~w_sel;
            c1_req_ready   = w_sel;
            w_owner_nxt    = w_sel;
            w_cnt_nxt      = mem_req_len;
            w_state_nxt    = mem_req_opcode ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          mem_wr_valid = r_owner ? c1_wr_valid : c0_wr_valid;
          mem_wr_bits  = r_owner ? c1_wr_bits  : c0_wr_bits;
          w_beat       = mem_wr_valid;
        end
        ST_READ: begin
          mem_rd_ready = r_owner ? c1_rd_ready : c0_rd_ready;
          if (r_owner) begin
            c1_rd_valid = mem_rd_valid;
            c1_rd_bits  = mem_rd_bits;
          end else begin
            c0_rd_valid = mem_rd_valid;
            c0_rd_bits  = mem_rd_bits;
          end
          w_beat = mem_rd_valid && mem_rd_ready;
        end
        default: w_state_nxt = ST_IDLE;
      endcase

      if (w_beat) begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = ~r_owner;
        end else begin
          w_cnt_nxt = r_cnt - LP_ONE;
        end
      end
    end
  end

  assign busy  = (r_state != ST_IDLE);
  assign owner = r_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change on the falling edge, outputs checked 1 unit later.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        c0_req_valid, c0_req_ready, c0_req_opcode;
  logic [7:0]  c0_req_len;
  logic [63:0] c0_req_addr;
  logic        c0_wr_valid;
  logic [63:0] c0_wr_bits;
  logic        c0_rd_valid;
  logic [63:0] c0_rd_bits;
  logic        c0_rd_ready;
  logic        c1_req_valid, c1_req_ready, c1_req_opcode;
  logic [7:0]  c1_req_len;
  logic [63:0] c1_req_addr;
  logic        c1_wr_valid;
  logic [63:0] c1_wr_bits;
  logic        c1_rd_valid;
  logic [63:0] c1_rd_bits;
  logic        c1_rd_ready;
  logic        mem_req_valid, mem_req_opcode;
  logic [7:0]  mem_req_len;
  logic [63:0] mem_req_addr;
  logic        mem_wr_valid;
  logic [63:0] mem_wr_bits;
  logic        mem_rd_valid;
  logic [63:0] mem_rd_bits;
  logic        mem_rd_ready;
  logic        busy, owner;

  int n_cmp;
  int n_err;
  int n_beats;
  logic pat [5];

  mem_arbiter #(.MEM_LEN_BITS(8), .MEM_ADDR_BITS(64), .MEM_DATA_BITS(64)) dut (
    .clock(clock), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_ready(c0_req_ready), .c0_req_opcode(c0_req_opcode),
    .c0_req_len(c0_req_len), .c0_req_addr(c0_req_addr), .c0_wr_valid(c0_wr_valid),
    .c0_wr_bits(c0_wr_bits), .c0_rd_valid(c0_rd_valid), .c0_rd_bits(c0_rd_bits),
    .c0_rd_ready(c0_rd_ready),
    .c1_req_valid(c1_req_valid), .c1_req_ready(c1_req_ready), .c1_req_opcode(c1_req_opcode),
    .c1_req_len(c1_req_len), .c1_req_addr(c1_req_addr), .c1_wr_valid(c1_wr_valid),
    .c1_wr_bits(c1_wr_bits), .c1_rd_valid(c1_rd_valid), .c1_rd_bits(c1_rd_bits),
    .c1_rd_ready(c1_rd_ready),
    .mem_req_valid(mem_req_valid), .mem_req_opcode(mem_req_opcode), .mem_req_len(mem_req_len),
    .mem_req_addr(mem_req_addr), .mem_wr_valid(mem_wr_valid), .mem_wr_bits(mem_wr_bits),
    .mem_rd_valid(mem_rd_valid), .mem_rd_bits(mem_rd_bits), .mem_rd_ready(mem_rd_ready),
    .busy(busy), .owner(owner)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    c0_req_valid = 0; c0_req_opcode = 0; c0_req_len = 0; c0_req_addr = 0;
    c0_wr_valid = 0; c0_wr_bits = 0; c0_rd_ready = 0;
    c1_req_valid = 0; c1_req_opcode = 0; c1_req_len = 0; c1_req_addr = 0;
    c1_wr_valid = 0; c1_wr_bits = 0; c1_rd_ready = 0;
    mem_rd_valid = 0; mem_rd_bits = 0;
  endtask

  task automatic req(input bit c, input logic op, input logic [7:0] len, input logic [63:0] addr);
    if (c) begin
      c1_req_valid = 1; c1_req_opcode = op; c1_req_len = len; c1_req_addr = addr;
    end else begin
      c0_req_valid = 1; c0_req_opcode = op; c0_req_len = len; c0_req_addr = addr;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 0; pat[4] = 1;
    clear_inputs();
    reset = 0;
    req(0, 0, 8'd3, 64'h1000);
    req(1, 1, 8'd3, 64'h2000);

    // Reset: requests present but everything held low
    repeat (2) @(negedge clock);
    #1;
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_c0_req_ready", c0_req_ready, 0);
    check("rst_c1_req_ready", c1_req_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    @(negedge clock);
    clear_inputs();
    reset = 1;

    // Contention: c0 wins first (rr=0), then c1, then c0 again
    @(negedge clock);
    req(0, 0, 8'd1, 64'h2000);
    req(1, 1, 8'd0, 64'h3000);
    #1;
    check("ct_c0_ready", c0_req_ready, 1);
    check("ct_c1_ready", c1_req_ready, 0);
    check("ct_addr", mem_req_addr, 64'h2000);
    @(negedge clock);
    c0_req_valid = 0; c0_rd_ready = 1; mem_rd_valid = 1; mem_rd_bits = 64'h11;
    #1;
    check("ct_c1_wait", c1_req_ready, 0);
    check("ct_req_locked", mem_req_valid, 0);
    check("ct_c0_rd_valid", c0_rd_valid, 1);
    @(negedge clock);
    mem_rd_bits = 64'h22;
    #1;
    check("ct_busy_beat2", busy, 1);
    @(negedge clock);
    mem_rd_valid = 0;
    #1;
    check("ct_busy_idle", busy, 0);
    check("ct_c1_granted", c1_req_ready, 1);
    check("ct_c1_opcode", mem_req_opcode, 1);
    check("ct_c1_addr", mem_req_addr, 64'h3000);
    @(negedge clock);
    c1_req_valid = 0; c1_wr_valid = 1; c1_wr_bits = 64'h55;
    #1;
    check("ct_wr_valid", mem_wr_valid, 1);
    check("ct_wr_bits", mem_wr_bits, 64'h55);
    check("ct_owner1", owner, 1);
    @(negedge clock);
    c1_wr_valid = 0;
    req(0, 0, 8'd0, 64'h2100);
    req(1, 1, 8'd0, 64'h3100);
    #1;
    check("ct3_busy", busy, 0);
    check("ct3_c0_ready", c0_req_ready, 1);
    check("ct3_c1_ready", c1_req_ready, 0);
    @(negedge clock);
    c0_req_valid = 0; c1_req_valid = 0; mem_rd_valid = 1;
    #1;
    check("ct3_c0_rd_valid", c0_rd_valid, 1);
    @(negedge clock);
    clear_inputs();
    #1;
    check("ct3_done", busy, 0);

    // Single client read, len=3
    @(negedge clock);
    req(0, 0, 8'd3, 64'h1000);
    #1;
    check("sr_req_valid", mem_req_valid, 1);
    check("sr_req_len", mem_req_len, 3);
    check("sr_req_addr", mem_req_addr, 64'h1000);
    check("sr_req_opcode", mem_req_opcode, 0);
    check("sr_c0_ready", c0_req_ready, 1);
    check("sr_c1_ready", c1_req_ready, 0);
    @(negedge clock);
    c0_req_valid = 0; c0_rd_ready = 1;
    #1;
    check("sr_busy", busy, 1);
    check("sr_req_low", mem_req_valid, 0);
    check("sr_owner", owner, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      mem_rd_valid = 1; mem_rd_bits = 64'hA0 + 64'(i);
      #1;
      check("sr_c0_rd_valid", c0_rd_valid, 1);
      check("sr_c0_rd_bits", c0_rd_bits, 64'hA0 + 64'(i));
      check("sr_c1_rd_valid", c1_rd_valid, 0);
      check("sr_c1_rd_bits", c1_rd_bits, 0);
      check("sr_mem_rd_ready", mem_rd_ready, 1);
      check("sr_busy_beat", busy, 1);
    end
    @(negedge clock);
    clear_inputs();
    #1;
    check("sr_busy_drop", busy, 0);

    // Write with gaps: c1 len=2, valid 1,0,1,0,1; c0 write pulses ignored
    @(negedge clock);
    req(1, 1, 8'd2, 64'h4000);
    #1;
    check("wg_c1_ready", c1_req_ready, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      c1_req_valid = 0;
      c1_wr_valid = pat[k]; c1_wr_bits = 64'h100 + 64'(k);
      c0_wr_valid = 1; c0_wr_bits = 64'hDEAD;
      #1;
      check("wg_wr_valid", mem_wr_valid, pat[k]);
      if (pat[k]) check("wg_wr_bits", mem_wr_bits, 64'h100 + 64'(k));
      check("wg_busy", busy, 1);
    end
    @(negedge clock);
    clear_inputs();
    c0_wr_valid = 1;
    #1;
    check("wg_done", busy, 0);
    check("wg_idle_wr", mem_wr_valid, 0);

    // Backpressure: c0 read len=1, three stalled cycles
    @(negedge clock);
    clear_inputs();
    req(0, 0, 8'd1, 64'h5000);
    #1;
    check("bp_c0_ready", c0_req_ready, 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      c0_req_valid = 0; mem_rd_valid = 1; c0_rd_ready = 0;
      #1;
      check("bp_stall_rdy", mem_rd_ready, 0);
      check("bp_stall_valid", c0_rd_valid, 1);
      check("bp_stall_busy", busy, 1);
    end
    @(negedge clock);
    c0_rd_ready = 1;
    #1;
    check("bp_beat1_rdy", mem_rd_ready, 1);
    check("bp_beat1_busy", busy, 1);
    @(negedge clock);
    #1;
    check("bp_beat2_busy", busy, 1);
    @(negedge clock);
    clear_inputs();
    #1;
    check("bp_done", busy, 0);

    // len=255 read by c1 takes exactly 256 beats
    @(negedge clock);
    req(1, 0, 8'd255, 64'h6000);
    #1;
    check("lb_c1_ready", c1_req_ready, 1);
    check("lb_len", mem_req_len, 255);
    @(negedge clock);
    c1_req_valid = 0; mem_rd_valid = 1; c1_rd_ready = 1;
    #1;
    n_beats = 0;
    while (busy && n_beats < 400) begin
      n_beats++;
      @(negedge clock);
      #1;
    end
    check("lb_beats", n_beats, 256);
    clear_inputs();

    // len=0 write by c0 is a single beat
    @(negedge clock);
    req(0, 1, 8'd0, 64'h7000);
    #1;
    check("sb_c0_ready", c0_req_ready, 1);
    check("sb_opcode", mem_req_opcode, 1);
    @(negedge clock);
    c0_req_valid = 0; c0_wr_valid = 1; c0_wr_bits = 64'h77;
    #1;
    check("sb_wr_valid", mem_wr_valid, 1);
    check("sb_wr_bits", mem_wr_bits, 64'h77);
    @(negedge clock);
    c0_wr_valid = 0;
    #1;
    check("sb_done", busy, 0);

    // Reset during beat 2 of a c1 len=5 read (rr=1 beforehand)
    @(negedge clock);
    req(1, 0, 8'd5, 64'h8000);
    #1;
    check("mr_c1_ready", c1_req_ready, 1);
    @(negedge clock);
    c1_req_valid = 0; mem_rd_valid = 1; c1_rd_ready = 1; mem_rd_bits = 64'hBEEF;
    #1;
    check("mr_beat1", c1_rd_valid, 1);
    check("mr_owner1", owner, 1);
    @(negedge clock);
    reset = 0;
    req(1, 0, 8'd0, 64'h9000);
    #1;
    check("mr_rd_valid", c1_rd_valid, 0);
    check("mr_rd_bits", c1_rd_bits, 0);
    check("mr_rd_ready", mem_rd_ready, 0);
    check("mr_busy", busy, 0);
    check("mr_owner", owner, 0);
    check("mr_req_valid", mem_req_valid, 0);
    check("mr_c1_ready_rst", c1_req_ready, 0);
    @(negedge clock);
    reset = 1; mem_rd_valid = 0; c1_rd_ready = 0;
    req(0, 0, 8'd0, 64'hA000);
    #1;
    check("mr_rr0_c0", c0_req_ready, 1);
    check("mr_rr0_c1", c1_req_ready, 0);
    @(negedge clock);
    c0_req_valid = 0; mem_rd_valid = 1; c0_rd_ready = 1;
    #1;
    check("mr_c0_beat", c0_rd_valid, 1);
    @(negedge clock);
    mem_rd_valid = 0; c0_rd_ready = 0;
    #1;
    check("mr_c1_granted", c1_req_ready, 1);
    check("mr_c1_addr", mem_req_addr, 64'h9000);
    @(negedge clock);
    clear_inputs();
    #1;
    check("mr_c1_busy", busy, 1);
    check("mr_c1_owner", owner, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
